// File: rtl/jt6295_rom_arb.sv
// Shared-ROM read arbiter: SLOTS requesters, per-slot last-address cache, one ROM access at a time.
// Latency: grant edge, then OKDLY+1 consecutive rom_ok cycles; slot_ok rises on the completing edge.
// Backpressure: slots hold slot_cs until slot_ok; rom_ok low stretches WAIT; one IDLE cycle between accesses.
module jt6295_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 18,
    parameter int DW    = 8,
    parameter int OKDLY = 3,
    parameter int RR    = 0
) (
    input  logic                rst,
    input  logic                clk,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [AW-1:0]       rom_addr,
    output logic                rom_cs,
    input  logic [DW-1:0]       rom_data,
    input  logic                rom_ok
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]    last [SLOTS];
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] pending;
    logic             any_pend;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    gnt;
    logic [IW-1:0]    rr_ptr;
    logic [2:0]       okcnt;
    logic             complete;
    logic [AW-1:0]    gnt_addr;
    logic             match;

    always_comb begin
        hit     = '0;
        pending = '0;
        for (int i = 0; i < SLOTS; i++) begin
            hit[i]     = valid[i] && (slot_addr[i*AW +: AW] == last[i]);
            pending[i] = slot_cs[i] && !hit[i];
        end
    end

    // Descending scan so the first candidate in search order is the one that sticks.
    always_comb begin
        sel      = '0;
        any_pend = |pending;
        if (RR == 0) begin
            for (int k = SLOTS - 1; k >= 0; k--) begin
                if (pending[k]) sel = IW'(k);
            end
        end else begin
            for (int k = SLOTS - 1; k >= 0; k--) begin
                if (pending[(int'(rr_ptr) + 1 + k) % SLOTS])
                    sel = IW'((int'(rr_ptr) + 1 + k) % SLOTS);
            end
        end
    end

    assign gnt_addr = slot_addr[int'(gnt)*AW +: AW];
    assign match    = (gnt_addr == rom_addr);
    assign complete = (state == WAIT) && rom_ok && (okcnt == 3'(OKDLY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = WAIT;
            WAIT:    if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            okcnt    <= '0;
            gnt      <= '0;
            rr_ptr   <= IW'(SLOTS - 1);
        end else if (state == IDLE) begin
            if (any_pend) begin
                gnt      <= sel;
                rr_ptr   <= sel;
                rom_addr <= slot_addr[int'(sel)*AW +: AW];
                rom_cs   <= 1'b1;
                okcnt    <= '0;
            end
        end else begin
            // Only an unbroken run of rom_ok counts towards completion.
            if (!rom_ok)
                okcnt <= '0;
            else if (okcnt < 3'(OKDLY))
                okcnt <= okcnt + 3'd1;
            if (complete)
                rom_cs <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_dout <= '0;
            slot_ok   <= '0;
            valid     <= '0;
            for (int i = 0; i < SLOTS; i++) last[i] <= '0;
        end else begin
            slot_ok <= hit;
            if (complete) begin
                // The requester may have moved on while the ROM was busy; stale data is dropped.
                if (match) begin
                    slot_dout[int'(gnt)*DW +: DW] <= rom_data;
                    last[gnt]    <= rom_addr;
                    valid[gnt]   <= 1'b1;
                    slot_ok[gnt] <= 1'b1;
                end else begin
                    valid[gnt]   <= 1'b0;
                    slot_ok[gnt] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Bench for jt6295_rom_arb: a fixed-priority and a round-robin instance share stimulus;
// directed scenarios plus a randomized run against a transaction-level model.
module tb_jt6295_rom_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 18;
    localparam int DW    = 8;
    localparam int OKDLY = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic                rom_ok;
    logic [SLOTS*DW-1:0] dout  [2];
    logic [SLOTS-1:0]    sok   [2];
    logic [AW-1:0]       raddr [2];
    logic [1:0]          rcs;
    logic [DW-1:0]       rdata [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> 5) ^ 18'h2A5C3;
        return t[DW-1:0];
    endfunction

    assign rdata[0] = romf(raddr[0]);
    assign rdata[1] = romf(raddr[1]);

    jt6295_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .OKDLY(OKDLY), .RR(0)) u_fix (
        .rst(rst), .clk(clk), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(dout[0]), .slot_ok(sok[0]), .rom_addr(raddr[0]), .rom_cs(rcs[0]),
        .rom_data(rdata[0]), .rom_ok(rom_ok)
    );

    jt6295_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .OKDLY(OKDLY), .RR(1)) u_rr (
        .rst(rst), .clk(clk), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(dout[1]), .slot_ok(sok[1]), .rom_addr(raddr[1]), .rom_cs(rcs[1]),
        .rom_data(rdata[1]), .rom_ok(rom_ok)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst = 1'b1; slot_cs = '0; slot_addr = '0; rom_ok = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    // Steps until the fixed-priority instance drops rom_cs; returns 64 on timeout.
    task automatic wait_idle(output int n);
        n = 0;
        while (rcs[0] && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; slot_cs = '0; slot_addr = '0; rom_ok = 1'b0;
        step(); step();
        for (int m = 0; m < 2; m++) begin
            checks++; if (rcs[m] !== 1'b0) begin errors++; $display("FAIL reset_rom_cs m=%0d got=%b exp=0", m, rcs[m]); end
            checks++; if (raddr[m] !== '0) begin errors++; $display("FAIL reset_rom_addr m=%0d got=%h exp=0", m, raddr[m]); end
            checks++; if (sok[m] !== '0) begin errors++; $display("FAIL reset_slot_ok m=%0d got=%b exp=0", m, sok[m]); end
            checks++; if (dout[m] !== '0) begin errors++; $display("FAIL reset_slot_dout m=%0d got=%h exp=0", m, dout[m]); end
        end
        rst = 1'b0;
        step();
        checks++; if (rcs !== 2'b00) begin errors++; $display("FAIL reset_idle got=%b exp=00", rcs); end
    endtask

    task automatic test_single_read();
        int n;
        logic [SLOTS*DW-1:0] expd;
        do_reset();
        set_addr(1, 18'h00123); slot_cs = 4'b0010; rom_ok = 1'b1;
        step();
        for (int m = 0; m < 2; m++) begin
            checks++; if (rcs[m] !== 1'b1) begin errors++; $display("FAIL single_grant m=%0d got=%b exp=1", m, rcs[m]); end
            checks++; if (raddr[m] !== 18'h00123) begin errors++; $display("FAIL single_addr m=%0d got=%h exp=00123", m, raddr[m]); end
        end
        wait_idle(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", n); end
        expd = '0;
        expd[DW +: DW] = romf(18'h00123);
        for (int m = 0; m < 2; m++) begin
            checks++; if (sok[m] !== 4'b0010) begin errors++; $display("FAIL single_ok m=%0d got=%b exp=0010", m, sok[m]); end
            checks++; if (dout[m] !== expd) begin errors++; $display("FAIL single_dout m=%0d got=%h exp=%h", m, dout[m], expd); end
        end
        step();
        checks++; if (rcs !== 2'b00 || sok[0] !== 4'b0010) begin
            errors++; $display("FAIL single_hold cs=%b ok=%b exp cs=00 ok=0010", rcs, sok[0]);
        end
    endtask

    task automatic test_priority();
        logic [AW-1:0] order [2][3];
        int   cnt [2];
        logic prev [2];
        do_reset();
        set_addr(0, 18'h00100); set_addr(2, 18'h00200); set_addr(3, 18'h00300);
        slot_cs = 4'b1101; rom_ok = 1'b1;
        cnt[0] = 0; cnt[1] = 0; prev[0] = 1'b0; prev[1] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (rcs[m] && !prev[m]) begin
                    if (cnt[m] < 3) order[m][cnt[m]] = raddr[m];
                    cnt[m]++;
                end
                prev[m] = rcs[m];
            end
        end
        for (int m = 0; m < 2; m++) begin
            checks++; if (cnt[m] !== 3) begin errors++; $display("FAIL prio_count m=%0d got=%0d exp=3", m, cnt[m]); end
            else begin
                checks++; if (order[m][0] !== 18'h00100 || order[m][1] !== 18'h00200 || order[m][2] !== 18'h00300) begin
                    errors++; $display("FAIL prio_order m=%0d got=%h,%h,%h exp=100,200,300", m, order[m][0], order[m][1], order[m][2]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        set_addr(2, 18'h00200); slot_cs = 4'b0100; rom_ok = 1'b1;
        step();
        wait_idle(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL rr_first_latency got=%0d exp=4", n); end
        set_addr(0, 18'h00100); set_addr(3, 18'h00300); slot_cs = 4'b1001;
        step();
        checks++; if (rcs[0] !== 1'b1 || raddr[0] !== 18'h00100) begin
            errors++; $display("FAIL rr_fixed_pick cs=%b addr=%h exp cs=1 addr=00100", rcs[0], raddr[0]);
        end
        checks++; if (rcs[1] !== 1'b1 || raddr[1] !== 18'h00300) begin
            errors++; $display("FAIL rr_rotate_pick cs=%b addr=%h exp cs=1 addr=00300", rcs[1], raddr[1]);
        end
    endtask

    task automatic test_ok_glitch();
        do_reset();
        set_addr(1, 18'h00055); slot_cs = 4'b0010; rom_ok = 1'b0;
        step();
        rom_ok = 1'b1; step(); step();
        rom_ok = 1'b0; step();
        checks++; if (rcs !== 2'b11) begin errors++; $display("FAIL glitch_hold got=%b exp=11", rcs); end
        rom_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (rcs !== ((k < 3) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL glitch_run k=%0d got=%b exp=%b", k, rcs, (k < 3) ? 2'b11 : 2'b00);
            end
        end
        checks++; if (sok[0] !== 4'b0010 || sok[1] !== 4'b0010) begin
            errors++; $display("FAIL glitch_ok got=%b/%b exp=0010", sok[0], sok[1]);
        end
    endtask

    task automatic test_hit_change();
        int n;
        do_reset();
        set_addr(0, 18'h00123); slot_cs = 4'b0001; rom_ok = 1'b1;
        step();
        wait_idle(n);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (rcs !== 2'b00 || sok[0][0] !== 1'b1) begin
                errors++; $display("FAIL hit_hold k=%0d cs=%b ok=%b exp cs=00 ok=1", k, rcs, sok[0][0]);
            end
        end
        set_addr(0, 18'h00124);
        step();
        for (int m = 0; m < 2; m++) begin
            checks++; if (sok[m][0] !== 1'b0) begin errors++; $display("FAIL change_ok_drop m=%0d got=%b exp=0", m, sok[m][0]); end
            checks++; if (rcs[m] !== 1'b1 || raddr[m] !== 18'h00124) begin
                errors++; $display("FAIL change_new_access m=%0d cs=%b addr=%h exp cs=1 addr=00124", m, rcs[m], raddr[m]);
            end
        end
        wait_idle(n);
        checks++; if (sok[0][0] !== 1'b1 || dout[0][0 +: DW] !== romf(18'h00124)) begin
            errors++; $display("FAIL change_data ok=%b dout=%h exp ok=1 dout=%h", sok[0][0], dout[0][0 +: DW], romf(18'h00124));
        end
    endtask

    task automatic test_mid_change();
        int n;
        do_reset();
        set_addr(3, 18'h00333); slot_cs = 4'b1000; rom_ok = 1'b0;
        step();
        set_addr(3, 18'h00334); rom_ok = 1'b1;
        for (int k = 0; k < 4; k++) step();
        for (int m = 0; m < 2; m++) begin
            checks++; if (rcs[m] !== 1'b0) begin errors++; $display("FAIL mid_complete m=%0d got=%b exp=0", m, rcs[m]); end
            checks++; if (sok[m][3] !== 1'b0 || dout[m][3*DW +: DW] !== '0) begin
                errors++; $display("FAIL mid_discard m=%0d ok=%b dout=%h exp ok=0 dout=00", m, sok[m][3], dout[m][3*DW +: DW]);
            end
        end
        step();
        checks++; if (rcs[0] !== 1'b1 || raddr[0] !== 18'h00334) begin
            errors++; $display("FAIL mid_reissue cs=%b addr=%h exp cs=1 addr=00334", rcs[0], raddr[0]);
        end
        wait_idle(n);
        checks++; if (sok[0][3] !== 1'b1 || dout[0][3*DW +: DW] !== romf(18'h00334)) begin
            errors++; $display("FAIL mid_data ok=%b dout=%h exp ok=1 dout=%h", sok[0][3], dout[0][3*DW +: DW], romf(18'h00334));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        set_addr(0, 18'h00077); slot_cs = 4'b0001; rom_ok = 1'b1;
        step();
        wait_idle(n);
        set_addr(2, 18'h00088); slot_cs = 4'b0101;
        step(); step(); step();
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rcs[m] !== 1'b0 || raddr[m] !== '0 || sok[m] !== '0 || dout[m] !== '0) begin
                errors++; $display("FAIL rstmid_clear m=%0d cs=%b addr=%h ok=%b dout=%h exp all 0", m, rcs[m], raddr[m], sok[m], dout[m]);
            end
        end
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rcs !== 2'b00) begin errors++; $display("FAIL rstmid_no_early got=%b exp=00", rcs); end
        step();
        for (int m = 0; m < 2; m++) begin
            checks++; if (rcs[m] !== 1'b1 || raddr[m] !== 18'h00077) begin
                errors++; $display("FAIL rstmid_restart m=%0d cs=%b addr=%h exp cs=1 addr=00077", m, rcs[m], raddr[m]);
            end
        end
        wait_idle(n);
        checks++; if (n !== 4 || sok[0] !== 4'b0001 || dout[0][0 +: DW] !== romf(18'h00077)) begin
            errors++; $display("FAIL rstmid_data n=%0d ok=%b dout=%h exp n=4 ok=0001 dout=%h", n, sok[0], dout[0][0 +: DW], romf(18'h00077));
        end
    endtask

    task automatic test_random();
        logic [AW-1:0]       mlast [2][SLOTS];
        logic [DW-1:0]       mdout [2][SLOTS];
        logic [SLOTS-1:0]    mvalid [2];
        logic [SLOTS-1:0]    mok [2];
        logic                mbusy [2];
        logic [AW-1:0]       mraddr [2];
        int                  mg [2];
        int                  mrun [2];
        int                  mptr [2];
        logic [SLOTS-1:0]    hitv, pend;
        logic [SLOTS*DW-1:0] expd;
        logic [AW-1:0]       a;
        int                  g, idx;
        rst = 1'b1; rom_ok = 1'b0; slot_cs = '0;
        for (int c = 0; c < 800; c++) begin
            if (c > 0) begin
                rst = ($urandom_range(0, 199) == 0);
                for (int i = 0; i < SLOTS; i++) begin
                    if ($urandom_range(0, 3) == 0) slot_cs[i] = ~slot_cs[i];
                    if ($urandom_range(0, 5) == 0) set_addr(i, AW'((i << 3) | int'($urandom_range(0, 7))));
                end
                rom_ok = ($urandom_range(0, 3) != 0);
            end
            step();
            for (int m = 0; m < 2; m++) begin
                if (rst) begin
                    mvalid[m] = '0; mok[m] = '0; mbusy[m] = 1'b0; mraddr[m] = '0;
                    mrun[m] = 0; mg[m] = 0; mptr[m] = SLOTS - 1;
                    for (int i = 0; i < SLOTS; i++) begin mlast[m][i] = '0; mdout[m][i] = '0; end
                end else begin
                    for (int i = 0; i < SLOTS; i++) begin
                        hitv[i] = mvalid[m][i] && (slot_addr[i*AW +: AW] == mlast[m][i]);
                        pend[i] = slot_cs[i] && !hitv[i];
                    end
                    mok[m] = hitv;
                    if (!mbusy[m]) begin
                        if (pend != '0) begin
                            g = -1;
                            for (int k = 0; k < SLOTS; k++) begin
                                idx = (m == 0) ? k : (mptr[m] + 1 + k) % SLOTS;
                                if (g < 0 && pend[idx]) g = idx;
                            end
                            mbusy[m] = 1'b1; mg[m] = g; mptr[m] = g; mrun[m] = 0;
                            mraddr[m] = slot_addr[g*AW +: AW];
                        end
                    end else begin
                        mrun[m] = rom_ok ? mrun[m] + 1 : 0;
                        if (mrun[m] == OKDLY + 1) begin
                            mbusy[m] = 1'b0;
                            a = slot_addr[mg[m]*AW +: AW];
                            if (a == mraddr[m]) begin
                                mdout[m][mg[m]] = romf(mraddr[m]);
                                mlast[m][mg[m]] = mraddr[m];
                                mvalid[m][mg[m]] = 1'b1;
                                mok[m][mg[m]] = 1'b1;
                            end else begin
                                mvalid[m][mg[m]] = 1'b0;
                                mok[m][mg[m]] = 1'b0;
                            end
                        end
                    end
                end
                for (int i = 0; i < SLOTS; i++) expd[i*DW +: DW] = mdout[m][i];
                checks++; if (rcs[m] !== mbusy[m]) begin errors++; $display("FAIL rand_rom_cs m=%0d c=%0d got=%b exp=%b", m, c, rcs[m], mbusy[m]); end
                checks++; if (raddr[m] !== mraddr[m]) begin errors++; $display("FAIL rand_rom_addr m=%0d c=%0d got=%h exp=%h", m, c, raddr[m], mraddr[m]); end
                checks++; if (sok[m] !== mok[m]) begin errors++; $display("FAIL rand_slot_ok m=%0d c=%0d got=%b exp=%b", m, c, sok[m], mok[m]); end
                checks++; if (dout[m] !== expd) begin errors++; $display("FAIL rand_slot_dout m=%0d c=%0d got=%h exp=%h", m, c, dout[m], expd); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; slot_cs = '0; slot_addr = '0; rom_ok = 1'b0;
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_ok_glitch();
        test_hit_change();
        test_mid_change();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
